// File: rtl/simpleuart_pkg.sv
// Shared UART definitions: receiver FSM states, 8N1 frame constants and the
// default bit period that the transmitter also uses.
package simpleuart_pkg;

  // 50 MHz clock / 115200 baud.
  localparam int DEFAULT_CLK_DIV = 434;

  // 8N1 framing.
  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/simpleuart_rx_if.sv
// Byte-side interface of the UART receiver: head byte, valid, pop strobe,
// sticky error flags and their clear. The receiver is the master.
interface simpleuart_rx_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_re;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       err_clr;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    output rx_overrun,
    input  rx_re,
    input  err_clr
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_frame_err,
    input  rx_overrun,
    output rx_re,
    output err_clr
  );

endinterface

// File: rtl/simpleuart_rx_fifo.sv
// Show-ahead receive storage. DEPTH=1 gives a single holding register with
// the same push/pop/drop behaviour. A push while full is dropped (and flagged
// on drop) unless a pop happens in the same cycle.
module simpleuart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             drop,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int MEM_N = 1 << PTR_W;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [MEM_N];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  // A pop on an empty FIFO is ignored; a pop frees the slot for a same-cycle push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH-1.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write port.
  // NOTE: the data array is not reset; head is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/simpleuart_rx.sv
// 8N1 UART receiver with sticky frame-error / overrun flags.
// Build option: define SIMPLEUART_RX_FIFO_EN for a FIFO_DEPTH-entry receive
// FIFO; otherwise storage is a single holding register.
module simpleuart_rx
  import simpleuart_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic uart_rx,
  simpleuart_rx_if.master bus
);

`ifdef SIMPLEUART_RX_FIFO_EN
  localparam int DEPTH = FIFO_DEPTH;
`else
  localparam int DEPTH = 1;
`endif

  // Start edge waits half a bit so later samples land near mid-bit.
  localparam logic [15:0] HALF_LOAD = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL_LOAD = 16'(CLK_DIV - 1);

  logic       sync1;
  logic       sync2;
  logic       rx_prev;
  logic       start_edge;
  logic       tick;

  rx_state_e  state;
  rx_state_e  state_nxt;
  logic [15:0] bit_cnt;
  logic [15:0] bit_cnt_nxt;
  logic [2:0] bit_idx;
  logic [2:0] bit_idx_nxt;
  logic [7:0] shift;
  logic [7:0] shift_nxt;
  logic       push;
  logic       frame_err_set;

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_drop;
  logic [7:0] fifo_head;
  logic       frame_err;
  logic       overrun;

  // Two-flop synchronizer plus one history flop for falling-edge detection;
  // all reset to the idle line level so reset release never looks like a start.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= uart_rx;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  assign start_edge = rx_prev & ~sync2;
  assign tick       = (bit_cnt == '0);

  // FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  // Next-state, bit timing and push / frame-error decisions.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    bit_idx_nxt   = bit_idx;
    shift_nxt     = shift;
    push          = 1'b0;
    frame_err_set = 1'b0;

    if (state == ST_START || state == ST_DATA || state == ST_STOP) begin
      bit_cnt_nxt = tick ? FULL_LOAD : bit_cnt - 16'd1;
    end

    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          state_nxt   = ST_START;
          bit_cnt_nxt = HALF_LOAD;
        end
      end
      ST_START: begin
        if (tick) begin
          if (sync2 == START_BIT) begin
            state_nxt   = ST_DATA;
            bit_idx_nxt = '0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_nxt = {sync2, shift[7:1]};
          if (bit_idx == 3'(DATA_BITS - 1)) state_nxt = ST_STOP;
          else bit_idx_nxt = bit_idx + 3'd1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (sync2 == STOP_BIT) begin
            push      = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            frame_err_set = 1'b1;
            state_nxt     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (sync2) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  simpleuart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (shift),
    .pop       (bus.rx_re),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop),
    .head      (fifo_head)
  );

  // Sticky error flags; a new event wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_err_set | (frame_err & ~bus.err_clr);
      overrun   <= fifo_drop     | (overrun   & ~bus.err_clr);
    end
  end

  assign bus.rx_data      = fifo_head;
  assign bus.rx_valid     = ~fifo_empty;
  assign bus.rx_frame_err = frame_err;
  assign bus.rx_overrun   = overrun;

endmodule

// File: tb/tb_simpleuart_rx.sv
// Directed bench for simpleuart_rx at CLK_DIV=8, FIFO_DEPTH=4. Covers both the
// default holding-register build and the SIMPLEUART_RX_FIFO_EN build.
module tb_simpleuart_rx;
  import simpleuart_pkg::*;

  localparam int CLK_DIV = 8;
  localparam int FRAME   = 10 * CLK_DIV;
  // With inputs driven 1 ns after edge 0 of a frame, the stop bit is sampled
  // in cycle 78 and the byte is visible from cycle 79.
  localparam int STOP_CYC  = 78;
  localparam int VALID_CYC = 79;

  logic clk = 1'b0;
  logic resetn;
  logic uart_rx;
  int   total = 0;
  int   bad   = 0;
  int   fv;

  simpleuart_rx_if bus ();

  simpleuart_rx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .uart_rx (uart_rx),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n, input logic lvl);
    uart_rx = lvl;
    step(n);
  endtask

  task automatic pop();
    bus.rx_re = 1'b1;
    step(1);
    bus.rx_re = 1'b0;
  endtask

  task automatic clear();
    bus.err_clr = 1'b1;
    step(1);
    bus.err_clr = 1'b0;
  endtask

  // Serialize one frame; optional pop / clear strobes in a given cycle and an
  // early abort cycle. first_valid reports the cycle rx_valid first rose.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int pop_cyc,
                            input int clr_cyc, input int abort_cyc, output int first_valid);
    logic [9:0] bits;
    logic       prev;
    bits        = {stop, data, START_BIT};
    first_valid = -1;
    prev        = bus.rx_valid;
    for (int c = 0; c < FRAME; c++) begin
      if (c == abort_cyc) return;
      if (bus.rx_valid && !prev && first_valid < 0) first_valid = c;
      prev        = bus.rx_valid;
      uart_rx     = bits[c / CLK_DIV];
      bus.rx_re   = (c == pop_cyc);
      bus.err_clr = (c == clr_cyc);
      step(1);
    end
    bus.rx_re   = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] data);
    int unused_fv;
    send_frame(data, STOP_BIT, -1, -1, -1, unused_fv);
  endtask

  initial begin
    resetn      = 1'b0;
    uart_rx     = 1'b1;
    bus.rx_re   = 1'b0;
    bus.err_clr = 1'b0;
    step(3);
    check("reset_valid", 32'(bus.rx_valid), 0);
    check("reset_data", 32'(bus.rx_data), 0);
    check("reset_ferr", 32'(bus.rx_frame_err), 0);
    check("reset_ovr", 32'(bus.rx_overrun), 0);
    check("reset_state", 32'(dut.state), 32'(ST_IDLE));
    resetn = 1'b1;
    idle(5, 1'b1);

    // Basic reception and one-cycle push latency.
    send_frame(8'h55, STOP_BIT, -1, -1, -1, fv);
    check("valid_latency", 32'(fv), VALID_CYC);
    check("rx55_data", 32'(bus.rx_data), 32'h55);
    check("rx55_valid", 32'(bus.rx_valid), 1);
`ifdef SIMPLEUART_RX_FIFO_EN
    send(8'hA3);
    check("fifo_head55", 32'(bus.rx_data), 32'h55);
    pop();
    check("fifo_headA3", 32'(bus.rx_data), 32'hA3);
    check("fifo_validA3", 32'(bus.rx_valid), 1);
`endif
    pop();
    check("drain_valid", 32'(bus.rx_valid), 0);
    pop();
    check("pop_empty_ignored", 32'(bus.rx_valid), 0);

    // Short low glitch on an idle line.
    idle(2, 1'b0);
    idle(30, 1'b1);
    check("glitch_valid", 32'(bus.rx_valid), 0);
    check("glitch_ferr", 32'(bus.rx_frame_err), 0);
    check("glitch_ovr", 32'(bus.rx_overrun), 0);
    check("glitch_state", 32'(dut.state), 32'(ST_IDLE));

    // Bad stop bit, line held low, then recovery.
    send_frame(8'h3C, 1'b0, -1, -1, -1, fv);
    idle(20, 1'b0);
    check("break_state", 32'(dut.state), 32'(ST_BREAK));
    check("break_ferr", 32'(bus.rx_frame_err), 1);
    check("break_valid", 32'(bus.rx_valid), 0);
    idle(16, 1'b1);
    check("break_exit", 32'(dut.state), 32'(ST_IDLE));
    send(8'h12);
    check("after_break_data", 32'(bus.rx_data), 32'h12);
    check("after_break_valid", 32'(bus.rx_valid), 1);
    clear();
    check("ferr_cleared", 32'(bus.rx_frame_err), 0);
    pop();
    check("after_break_drain", 32'(bus.rx_valid), 0);

`ifdef SIMPLEUART_RX_FIFO_EN
    // Fill the 4-entry FIFO, overflow it, then push and pop together when full.
    for (int i = 1; i <= 4; i++) send(8'(i));
    check("fill_ovr", 32'(bus.rx_overrun), 0);
    send(8'h05);
    check("overflow_ovr", 32'(bus.rx_overrun), 1);
    check("overflow_head", 32'(bus.rx_data), 32'h01);
    clear();
    check("ovr_cleared", 32'(bus.rx_overrun), 0);
    send_frame(8'h06, STOP_BIT, STOP_CYC, -1, -1, fv);
    check("full_pushpop_ovr", 32'(bus.rx_overrun), 0);
    check("full_pushpop_head", 32'(bus.rx_data), 32'h02);
    pop();
    check("fifo_head03", 32'(bus.rx_data), 32'h03);
    pop();
    check("fifo_head04", 32'(bus.rx_data), 32'h04);
    pop();
    check("fifo_head06", 32'(bus.rx_data), 32'h06);
    pop();
    check("fifo_empty", 32'(bus.rx_valid), 0);
`else
    // Holding register: second byte dropped, then push and pop together.
    send(8'h11);
    send(8'h22);
    check("hold_head", 32'(bus.rx_data), 32'h11);
    check("hold_ovr", 32'(bus.rx_overrun), 1);
    clear();
    check("ovr_cleared", 32'(bus.rx_overrun), 0);
    pop();
    check("hold_drain", 32'(bus.rx_valid), 0);
    send(8'h11);
    send_frame(8'h22, STOP_BIT, STOP_CYC, -1, -1, fv);
    check("hold_pushpop_data", 32'(bus.rx_data), 32'h22);
    check("hold_pushpop_valid", 32'(bus.rx_valid), 1);
    check("hold_pushpop_ovr", 32'(bus.rx_overrun), 0);
    pop();
    check("hold_empty", 32'(bus.rx_valid), 0);
`endif

    // Clear coinciding with a new frame error: flag must stay set.
    send_frame(8'h5A, 1'b0, -1, STOP_CYC, -1, fv);
    idle(16, 1'b1);
    check("clr_vs_set_ferr", 32'(bus.rx_frame_err), 1);
    send(8'h77);
    check("pre_reset_data", 32'(bus.rx_data), 32'h77);

    // Reset in the middle of data bit 4 of 0xFF.
    send_frame(8'hFF, STOP_BIT, -1, -1, 4 * CLK_DIV + CLK_DIV + 4, fv);
    check("pre_reset_state", 32'(dut.state), 32'(ST_DATA));
    resetn = 1'b0;
    step(3);
    check("midreset_valid", 32'(bus.rx_valid), 0);
    check("midreset_data", 32'(bus.rx_data), 0);
    check("midreset_ferr", 32'(bus.rx_frame_err), 0);
    check("midreset_ovr", 32'(bus.rx_overrun), 0);
    check("midreset_state", 32'(dut.state), 32'(ST_IDLE));
    check("midreset_cnt", 32'(dut.bit_cnt), 0);
    resetn = 1'b1;
    idle(100, 1'b1);
    check("post_reset_valid", 32'(bus.rx_valid), 0);
    check("post_reset_ferr", 32'(bus.rx_frame_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
